// File: rtl/wb_simple_master.sv
// rtl/wb_simple_master.sv - single-outstanding Wishbone B4 pipelined master
// Turns a level request/complete handshake into one Wishbone cycle; every output is registered.
module wb_simple_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    wb_clk,
  input  logic                    reset,
  input  logic                    wb_rst,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  input  logic                    wb_stall,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    request,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_to_bus,
  input  logic [DATA_WIDTH/8-1:0] byte_sel,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   data_from_bus,
  output logic                    ready_from_bus,
  output logic                    error_from_bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    cyc_n, stb_n, we_n, busy_n, ready_n, err_n;
  logic [DATA_WIDTH/8-1:0] sel_n;
  logic [ADDR_WIDTH-1:0]   adr_n;
  logic [DATA_WIDTH-1:0]   dat_o_n, dfb_n;
  logic                    timeout_hit;

  // cnt is 0 on the edge after wb_cyc rises, so cnt==TIMEOUT-1 marks the TIMEOUT-th edge
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge wb_clk) begin
    if (!reset || wb_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      wb_cyc         <= 1'b0;
      wb_stb         <= 1'b0;
      wb_we          <= 1'b0;
      wb_sel         <= '0;
      wb_adr         <= '0;
      wb_dat_o       <= '0;
      busy           <= 1'b0;
      data_from_bus  <= '0;
      ready_from_bus <= 1'b0;
      error_from_bus <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      wb_cyc         <= cyc_n;
      wb_stb         <= stb_n;
      wb_we          <= we_n;
      wb_sel         <= sel_n;
      wb_adr         <= adr_n;
      wb_dat_o       <= dat_o_n;
      busy           <= busy_n;
      data_from_bus  <= dfb_n;
      ready_from_bus <= ready_n;
      error_from_bus <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cyc_n   = wb_cyc;
    stb_n   = wb_stb;
    we_n    = wb_we;
    sel_n   = wb_sel;
    adr_n   = wb_adr;
    dat_o_n = wb_dat_o;
    busy_n  = busy;
    dfb_n   = data_from_bus;
    ready_n = ready_from_bus;
    err_n   = error_from_bus;

    case (state)
      IDLE: begin
        if (request) begin
          state_n = REQ;
          cnt_n   = '0;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = write;
          sel_n   = byte_sel;
          adr_n   = address;
          dat_o_n = data_to_bus;
          busy_n  = 1'b1;
        end
      end
      REQ, WAIT: begin
        cnt_n = cnt + 1'b1;
        // a response ends the cycle even if it arrives while the strobe is still stalled
        if (wb_ack || wb_err || timeout_hit) begin
          state_n = DONE;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          sel_n   = '0;
          if (wb_err || !wb_ack) begin
            err_n = 1'b1;
          end else begin
            ready_n = 1'b1;
            if (!wb_we) dfb_n = wb_dat_i;
          end
        end else if (state == REQ && !wb_stall) begin
          state_n = WAIT;
          stb_n   = 1'b0;
        end
      end
      DONE: begin
        if (!request) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_simple_master.sv
// tb/tb_wb_simple_master.sv - directed self-checking bench for wb_simple_master
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_wb_simple_master;

  logic        wb_clk = 1'b0;
  logic        reset, wb_rst, wb_ack, wb_err, wb_stall;
  logic [31:0] wb_dat_i;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_o;
  logic        request, write;
  logic [31:0] address, data_to_bus;
  logic [3:0]  byte_sel;
  logic        busy, ready_from_bus, error_from_bus;
  logic [31:0] data_from_bus;

  int n_checks = 0;
  int n_fail   = 0;

  wb_simple_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk(wb_clk), .reset(reset), .wb_rst(wb_rst),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .wb_dat_i(wb_dat_i),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
    .request(request), .write(write), .address(address),
    .data_to_bus(data_to_bus), .byte_sel(byte_sel),
    .busy(busy), .data_from_bus(data_from_bus),
    .ready_from_bus(ready_from_bus), .error_from_bus(error_from_bus)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic cyc, input logic stb,
                         input logic we, input logic [3:0] sel);
    chk({tag, ".cyc"}, {31'd0, wb_cyc}, {31'd0, cyc});
    chk({tag, ".stb"}, {31'd0, wb_stb}, {31'd0, stb});
    chk({tag, ".we"},  {31'd0, wb_we},  {31'd0, we});
    chk({tag, ".sel"}, {28'd0, wb_sel}, {28'd0, sel});
  endtask

  task automatic chk_core(input string tag, input logic bsy, input logic rdy,
                          input logic err, input logic [31:0] dfb);
    chk({tag, ".busy"},  {31'd0, busy},           {31'd0, bsy});
    chk({tag, ".ready"}, {31'd0, ready_from_bus}, {31'd0, rdy});
    chk({tag, ".error"}, {31'd0, error_from_bus}, {31'd0, err});
    chk({tag, ".data"},  data_from_bus,           dfb);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_bus(tag, 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core(tag, 1'b0, 1'b0, 1'b0, 32'h0);
    chk({tag, ".adr"},   wb_adr,   32'h0);
    chk({tag, ".dat_o"}, wb_dat_o, 32'h0);
  endtask

  initial begin
    reset = 1'b0; wb_rst = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    wb_dat_i = 32'h0; request = 1'b0; write = 1'b0; address = 32'h0;
    data_to_bus = 32'h0; byte_sel = 4'h0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // write, slave acks two cycles after the strobe
    request = 1'b1; write = 1'b1; address = 32'h1000_0004;
    data_to_bus = 32'hDEAD_BEEF; byte_sel = 4'hF;
    tick();
    chk_bus("wr_strobe", 1'b1, 1'b1, 1'b1, 4'hF);
    chk("wr_strobe.adr", wb_adr, 32'h1000_0004);
    chk("wr_strobe.dat_o", wb_dat_o, 32'hDEAD_BEEF);
    chk_core("wr_strobe", 1'b1, 1'b0, 1'b0, 32'h0);
    address = 32'hFFFF_FFFF; data_to_bus = 32'h0; write = 1'b0;
    tick();
    chk_bus("wr_wait", 1'b1, 1'b0, 1'b1, 4'hF);
    chk("wr_wait.adr", wb_adr, 32'h1000_0004);
    chk("wr_wait.dat_o", wb_dat_o, 32'hDEAD_BEEF);
    wb_ack = 1'b1; wb_dat_i = 32'h5555_5555;
    tick();
    wb_ack = 1'b0;
    chk_bus("wr_done", 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core("wr_done", 1'b1, 1'b1, 1'b0, 32'h0);
    request = 1'b0;
    tick();
    chk_core("wr_idle", 1'b0, 1'b0, 1'b0, 32'h0);

    // read with the strobe stalled for three sampled edges
    request = 1'b1; write = 1'b0; address = 32'h2000_0000; byte_sel = 4'h3;
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bus($sformatf("rd_stall%0d", i), 1'b1, 1'b1, 1'b0, 4'h3);
      chk($sformatf("rd_stall%0d.adr", i), wb_adr, 32'h2000_0000);
      address = 32'h0BAD_0000 + i; byte_sel = 4'hC;
    end
    wb_stall = 1'b0;
    tick();
    chk_bus("rd_wait", 1'b1, 1'b0, 1'b0, 4'h3);
    wb_ack = 1'b1; wb_dat_i = 32'h1234_5678;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    chk_bus("rd_done", 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core("rd_done", 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    request = 1'b0;
    tick();
    chk_core("rd_idle", 1'b0, 1'b0, 1'b0, 32'h1234_5678);

    // write terminated by err together with ack: err wins, read data untouched
    request = 1'b1; write = 1'b1; address = 32'h3000_0008;
    data_to_bus = 32'hCAFE_F00D; byte_sel = 4'hC;
    tick();
    chk_bus("err_strobe", 1'b1, 1'b1, 1'b1, 4'hC);
    tick();
    wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = 32'h7777_7777;
    tick();
    wb_err = 1'b0; wb_ack = 1'b0;
    chk_bus("err_done", 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core("err_done", 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    request = 1'b0;
    tick();
    chk_core("err_idle", 1'b0, 1'b0, 1'b0, 32'h1234_5678);

    // ack while the strobe is still stalled; request held to prove no second strobe
    request = 1'b1; write = 1'b0; address = 32'h4000_0010; byte_sel = 4'h1;
    wb_stall = 1'b1;
    tick();
    chk_bus("ackstall_strobe", 1'b1, 1'b1, 1'b0, 4'h1);
    wb_ack = 1'b1; wb_dat_i = 32'hA5A5_5A5A;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    chk_bus("ackstall_done", 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core("ackstall_done", 1'b1, 1'b1, 1'b0, 32'hA5A5_5A5A);
    tick(); tick();
    chk_bus("ackstall_hold", 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core("ackstall_hold", 1'b1, 1'b1, 1'b0, 32'hA5A5_5A5A);
    request = 1'b0; wb_stall = 1'b0;
    tick();
    chk_core("ackstall_idle", 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A);

    // timeout: no response, error on the 8th edge after wb_cyc rises
    request = 1'b1; write = 1'b0; address = 32'h5000_0000; byte_sel = 4'hF;
    wb_stall = 1'b1;
    tick();
    chk_bus("to_strobe", 1'b1, 1'b1, 1'b0, 4'hF);
    wb_stall = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_wait%0d.cyc", i), {31'd0, wb_cyc}, 32'd1);
      chk($sformatf("to_wait%0d.error", i), {31'd0, error_from_bus}, 32'd0);
    end
    tick();
    chk_bus("to_done", 1'b0, 1'b0, 1'b0, 4'h0);
    chk_core("to_done", 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A);
    request = 1'b0;
    tick();
    chk_core("to_idle", 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A);

    // core reset in WAIT, then restart
    request = 1'b1; write = 1'b1; address = 32'h6000_0000;
    data_to_bus = 32'h0101_0101; byte_sel = 4'h5;
    tick(); tick();
    chk_bus("rst_wait", 1'b1, 1'b0, 1'b1, 4'h5);
    reset = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b1; address = 32'h6000_0040;
    tick();
    chk_bus("rst_restart", 1'b1, 1'b1, 1'b1, 4'h5);
    chk("rst_restart.adr", wb_adr, 32'h6000_0040);
    chk("rst_restart.dat_o", wb_dat_o, 32'h0101_0101);

    // bus reset in WAIT, then restart and complete
    tick();
    chk_bus("wbrst_wait", 1'b1, 1'b0, 1'b1, 4'h5);
    wb_rst = 1'b1;
    tick();
    chk_all_zero("wbrst_mid");
    wb_rst = 1'b0; address = 32'h7000_0080; write = 1'b0; byte_sel = 4'hA;
    tick();
    chk_bus("wbrst_restart", 1'b1, 1'b1, 1'b0, 4'hA);
    chk("wbrst_restart.adr", wb_adr, 32'h7000_0080);
    tick();
    wb_ack = 1'b1; wb_dat_i = 32'h0F0F_00FF;
    tick();
    wb_ack = 1'b0;
    chk_core("wbrst_done", 1'b1, 1'b1, 1'b0, 32'h0F0F_00FF);
    request = 1'b0;
    tick();
    chk_core("wbrst_idle", 1'b0, 1'b0, 1'b0, 32'h0F0F_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
